// File: rtl/riscv_soft_mem_arbiter.sv
// riscv_soft_mem_arbiter
// Shares one downstream memory request/response channel between the core's
// instruction-fetch port (I) and data port (D). One transaction is in flight
// at a time: IDLE -> ISSUE -> WAIT -> IDLE.
//
// Handshake: a request transfers on a cycle where *_valid && *_ready are both
// high; the requester holds its fields stable while valid is high and not yet
// accepted, and may drop valid at any time before acceptance. Responses are
// single-cycle strobes with no back-pressure.
//
// Optional build macro RISCV_SOFT_ARB_RR_EN: when defined, arbitration is
// round-robin on ties (the side not granted last wins; D wins the first tie).
// When undefined, D has fixed priority, except that a pending I request wins
// once it has lost STARVE_LIMIT consecutive arbitrations.
module riscv_soft_mem_arbiter #(
  parameter int XPR_LEN      = 32,
  parameter int OP_TYPE_W    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [XPR_LEN-1:0]   i_req_addr,
  output logic                 i_resp_valid,
  output logic [XPR_LEN-1:0]   i_resp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_op,
  input  logic [OP_TYPE_W-1:0] d_req_op_type,
  input  logic [XPR_LEN-1:0]   d_req_addr,
  input  logic [XPR_LEN-1:0]   d_req_data,
  output logic                 d_resp_valid,
  output logic [XPR_LEN-1:0]   d_resp_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_op,
  output logic [OP_TYPE_W-1:0] mem_req_op_type,
  output logic [XPR_LEN-1:0]   mem_req_addr,
  output logic [XPR_LEN-1:0]   mem_req_data,
  input  logic                 mem_resp_valid,
  input  logic [XPR_LEN-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  logic   owner_d;   // 1 = D owns the in-flight transaction, 0 = I
  logic   grant_i;
  logic   grant_d;

`ifdef RISCV_SOFT_ARB_RR_EN
  logic last_d;      // 1 = D was granted most recently

  // Round-robin tie break: both valid -> the side not granted last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && reset) begin
      if (i_req_valid && d_req_valid) begin
        grant_i = last_d;
        grant_d = !last_d;
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  // Remember which side won the most recent arbitration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d <= grant_d;
    end
  end
`else
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starve_full;

  assign starve_full = (starve_cnt == LIMIT_C);

  // Fixed D priority; a starved I request overrides it on a tie.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && reset) begin
      if (i_req_valid && d_req_valid) begin
        grant_i = starve_full;
        grant_d = !starve_full;
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  // Count consecutive arbitrations I lost while waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req_valid && !starve_full) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Main transaction FSM: capture request, present it downstream, route response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      owner_d         <= 1'b0;
      mem_req_valid   <= 1'b0;
      mem_req_op      <= 1'b0;
      mem_req_op_type <= '0;
      mem_req_addr    <= '0;
      mem_req_data    <= '0;
      i_resp_valid    <= 1'b0;
      i_resp_data     <= '0;
      d_resp_valid    <= 1'b0;
      d_resp_data     <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d         <= 1'b1;
            mem_req_valid   <= 1'b1;
            mem_req_op      <= d_req_op;
            mem_req_op_type <= d_req_op_type;
            mem_req_addr    <= d_req_addr;
            mem_req_data    <= d_req_data;
            state           <= ISSUE;
          end else if (grant_i) begin
            // Fetches are always word loads with no store data.
            owner_d         <= 1'b0;
            mem_req_valid   <= 1'b1;
            mem_req_op      <= 1'b0;
            mem_req_op_type <= OP_TYPE_W'(2);
            mem_req_addr    <= i_req_addr;
            mem_req_data    <= '0;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (owner_d) begin
              d_resp_valid <= 1'b1;
              d_resp_data  <= mem_resp_data;
            end else begin
              i_resp_valid <= 1'b1;
              i_resp_data  <= mem_resp_data;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_soft_mem_arbiter.sv
// Testbench for riscv_soft_mem_arbiter: directed steps followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_riscv_soft_mem_arbiter;

  localparam int XL = 32;
  localparam int OTW = 3;
  localparam int STARVE_LIMIT = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_req_valid, i_req_ready;
  logic [XL-1:0]  i_req_addr;
  logic           i_resp_valid;
  logic [XL-1:0]  i_resp_data;
  logic           d_req_valid, d_req_ready, d_req_op;
  logic [OTW-1:0] d_req_op_type;
  logic [XL-1:0]  d_req_addr, d_req_data;
  logic           d_resp_valid;
  logic [XL-1:0]  d_resp_data;
  logic           mem_req_valid, mem_req_ready, mem_req_op;
  logic [OTW-1:0] mem_req_op_type;
  logic [XL-1:0]  mem_req_addr, mem_req_data;
  logic           mem_resp_valid;
  logic [XL-1:0]  mem_resp_data;

  riscv_soft_mem_arbiter #(
    .XPR_LEN(XL), .OP_TYPE_W(OTW), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_op(d_req_op),
    .d_req_op_type(d_req_op_type), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_op(mem_req_op),
    .mem_req_op_type(mem_req_op_type), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  // Clock
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state: arbitration history and last delivered responses.
  int            m_lost;     // consecutive arbitrations I lost while requesting
  bit            m_last_d;   // last granted side was D
  logic [XL-1:0] m_i_data;
  logic [XL-1:0] m_d_data;

  task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lost = 0;
    m_last_d = 1'b0;
    m_i_data = '0;
    m_d_data = '0;
  endtask

  // Which side should win when the given valids are presented in IDLE.
  function automatic bit model_pick_d(input bit iv, input bit dv);
    if (iv && dv) begin
`ifdef RISCV_SOFT_ARB_RR_EN
      return !m_last_d;
`else
      return (m_lost < STARVE_LIMIT);
`endif
    end
    return dv;
  endfunction

  // Hold reset low for n checked cycles, then release at a posedge+1.
  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_i_ready", 32'(i_req_ready), 32'd0);
      check("rst_d_ready", 32'(d_req_ready), 32'd0);
      check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
      check("rst_resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
      check("rst_mem_addr", mem_req_addr, 32'd0);
      check("rst_mem_data", mem_req_data, 32'd0);
      check("rst_i_resp_data", i_resp_data, 32'd0);
      check("rst_d_resp_data", d_resp_data, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One full transaction starting at posedge+1 in IDLE. k = cycles of
  // mem_req_ready low, w = idle cycles in WAIT before the response.
  task automatic do_txn(input bit iv, input bit dv, input bit dop, input logic [OTW-1:0] dot,
                        input logic [XL-1:0] ia, input logic [XL-1:0] da, input logic [XL-1:0] dd,
                        input int k, input int w, input logic [XL-1:0] rdata, output bit obs_d);
    bit exp_d;
    logic [XL-1:0] e_addr, e_data;
    logic [OTW-1:0] e_ot;
    bit e_op;
    i_req_valid = iv; i_req_addr = ia;
    d_req_valid = dv; d_req_op = dop; d_req_op_type = dot; d_req_addr = da; d_req_data = dd;
    exp_d = model_pick_d(iv, dv);
    @(negedge clk);
    obs_d = d_req_ready;
    check("grant_i_ready", 32'(i_req_ready), 32'(!exp_d));
    check("grant_d_ready", 32'(d_req_ready), 32'(exp_d));
    @(posedge clk);
    #1;
    if (exp_d) begin
      if (iv) m_lost = (m_lost + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_lost + 1;
      e_op = dop; e_ot = dot; e_addr = da; e_data = dd;
    end else begin
      m_lost = 0;
      e_op = 1'b0; e_ot = 3'b010; e_addr = ia; e_data = '0;
    end
    m_last_d = exp_d;
    for (int c = 0; c <= k; c++) begin
      mem_req_ready = (c == k);
      @(negedge clk);
      check("issue_valid", 32'(mem_req_valid), 32'd1);
      check("issue_addr", mem_req_addr, e_addr);
      check("issue_data", mem_req_data, e_data);
      check("issue_op", {28'd0, mem_req_op_type, mem_req_op}, {28'd0, e_ot, e_op});
      check("issue_readys", {30'd0, i_req_ready, d_req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_req_ready = 1'b0;
    for (int c = 0; c < w; c++) begin
      @(negedge clk);
      check("wait_mem_valid", 32'(mem_req_valid), 32'd0);
      check("wait_resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    mem_resp_valid = 1'b1;
    mem_resp_data = rdata;
    @(negedge clk);
    check("wait_readys", {30'd0, i_req_ready, d_req_ready}, 32'd0);
    check("wait_mem_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    if (exp_d) m_d_data = rdata; else m_i_data = rdata;
    @(negedge clk);
    check("resp_i_valid", 32'(i_resp_valid), 32'(!exp_d));
    check("resp_d_valid", 32'(d_resp_valid), 32'(exp_d));
    check("resp_i_data", i_resp_data, m_i_data);
    check("resp_d_data", d_resp_data, m_d_data);
    @(posedge clk);
    #1;
    check("resp_pulse_once", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
  endtask

  // Watchdog: the directed sequence is bounded, so this only fires on a broken sim.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit exp_pat[10];
  bit got_d;

  initial begin
    reset = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h0000_0400;
    d_req_valid = 1'b1; d_req_op = 1'b0; d_req_op_type = 3'b010;
    d_req_addr = 32'h0000_0800; d_req_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();

    // Reset with both requesters valid, then back-to-back contention.
    do_reset(2);
    for (int j = 0; j < 10; j++) begin
`ifdef RISCV_SOFT_ARB_RR_EN
      exp_pat[j] = (j % 2 == 0);
`else
      exp_pat[j] = (j % (STARVE_LIMIT + 1) != STARVE_LIMIT);
`endif
    end
    for (int j = 0; j < 10; j++) begin
      do_txn(1'b1, 1'b1, 1'b0, 3'b010, 32'h1000 + 32'(4 * j), 32'h2000 + 32'(4 * j), 32'h0,
             0, 0, 32'hA000_0000 + 32'(j), got_d);
      check("starve_seq", 32'(got_d), 32'(exp_pat[j]));
    end

    // Single fetch with a zero-wait memory.
    do_txn(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 32'h0000_0013, got_d);

    // Store held off by mem_req_ready for 5 cycles.
    do_txn(1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 5, 1,
           32'h0000_0000, got_d);

    // Spurious downstream response while idle.
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0000_0055;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("spur_resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
    check("spur_i_data", i_resp_data, m_i_data);
    check("spur_d_data", d_resp_data, m_d_data);
    check("spur_mem_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reset while D waits for its response; the late response must be dropped.
    d_req_valid = 1'b1; d_req_op = 1'b0; d_req_addr = 32'h0000_0300;
    @(negedge clk);
    check("mid_d_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0000_0077;
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("mid_resp_valid", {30'd0, i_resp_valid, d_resp_valid}, 32'd0);
    check("mid_d_data", d_resp_data, 32'd0);
    check("mid_mem_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    do_txn(1'b0, 1'b1, 1'b0, 3'b001, 32'h0, 32'h0000_0304, 32'h0, 0, 0, 32'h1234_5678, got_d);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      bit iv, dv;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) dv = 1'b1;
      do_txn(iv, dv, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), $urandom, got_d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_soft_mem_arbiter.md
Name: riscv_soft_mem_arbiter

Overview:
- Shares one memory request/response port between the core's instruction-fetch port and data port.
- Sits between the core and the single external memory/cache channel.
- Accepts one transaction at a time from either requester, issues it downstream, waits for the response, and routes it back to the owner.
- Data side has fixed priority, with a starvation guard for fetch.

Parameters:
- XPR_LEN, 32, address/data width
- OP_TYPE_W, 3, width of the access-size field (byte/half/word encoding, passed through unmodified)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending I request wins

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle when high with valid
- i_req_addr  in  XPR_LEN  fetch address
- i_resp_valid  out  1  fetch response strobe
- i_resp_data  out  XPR_LEN  fetch response data
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_op  in  1  0=load, 1=store
- d_req_op_type  in  OP_TYPE_W  access size
- d_req_addr  in  XPR_LEN  data address
- d_req_data  in  XPR_LEN  store data
- d_resp_valid  out  1  data response strobe (loads and stores)
- d_resp_data  out  XPR_LEN  load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_req_op  out  1  0=load, 1=store
- mem_req_op_type  out  OP_TYPE_W  access size
- mem_req_addr  out  XPR_LEN  address
- mem_req_data  out  XPR_LEN  store data
- mem_resp_valid  in  1  downstream response strobe (one per request, stores included)
- mem_resp_data  in  XPR_LEN  response data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Owner register: I or D.
- Reset (reset==0 at a clk edge):
  - state=IDLE; all *_valid outputs 0; all data/addr/op outputs 0; starve counter 0.
  - Takes effect in any state and aborts any in-flight transaction; a later mem_resp_valid is ignored.
- IDLE:
  - Grant is combinational from the valids; only the winner sees ready=1; the loser's ready=0; both readys=0 outside IDLE.
  - Priority: D wins over I, unless starve counter == STARVE_LIMIT, in which case I wins.
  - On valid&&ready: latch op/op_type/addr/data into hold registers (I side: op=0, op_type=word encoding 3'b010, data=0), set owner, go to ISSUE.
- ISSUE:
  - mem_req_valid=1; mem_req_* driven from hold registers and stable until accepted.
  - On mem_req_ready: next state WAIT, mem_req_valid=0 from the next cycle.
- WAIT:
  - On mem_resp_valid: register mem_resp_data into owner's *_resp_data and pulse owner's *_resp_valid for exactly 1 cycle (the cycle after mem_resp_valid); return to IDLE on the same edge.
  - Non-owner resp_valid stays 0; resp_data holds its last value.
- mem_resp_valid in IDLE or ISSUE: ignored.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when I is valid in IDLE and D is granted.
  - Clears to 0 when I is granted.
  - Unchanged in other cycles.
- Latency: request accepted at cycle 0 -> mem_req_valid at cycle 1; zero-wait memory (ready at 1, resp at 2) -> resp strobe at cycle 3; next acceptance possible at cycle 3.
- Requesters may drop valid while not granted; no state is retained for unaccepted requests.

Optional Feature:
- Macro RISCV_SOFT_ARB_RR_EN.
- Defined: arbitration is round-robin. A last-granted register (reset value I, so D wins the first tie) gives priority to the other side when both are valid. Starve counter and STARVE_LIMIT are unused and must not affect behaviour.
- Undefined: fixed D priority with starvation guard, as described above.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with both valids=1 -> all valids/readys 0, outputs 0; release -> D granted in first IDLE cycle.
2. Single fetch: i_req_valid with addr=0x00000100, memory ready immediately, responds with 0x00000013 next cycle -> mem_req_addr=0x100 with op=0, i_resp_valid pulses once with data 0x13 at cycle 3, d_resp_valid never set.
3. Store backpressure: D store addr=0x200, data=0xDEADBEEF, op_type=2; mem_req_ready low 5 cycles -> mem_req_* stable for all 6 cycles; d_resp_valid pulses once after mem_resp_valid.
4. Starvation: both valid continuously, default STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I (with macro defined: D,I,D,I...).
5. Reset mid-WAIT: assert reset while owner D awaits response, then deliver mem_resp_valid after release -> no d_resp_valid or i_resp_valid pulse; state IDLE.
6. Spurious mem_resp_valid in IDLE with data 0x55 -> no resp strobe; resp_data registers unchanged.
